riscv_mem_port_arbiter: RTL and testbench

Arbitrates the core's instruction-fetch port and data-memory (load/store) port onto one shared memory request/response port. It sits between the fetch/memory pipeline stages and the single-ported memory interface. The block uses fixed data-over-fetch priority with bounded fetch starvation. It tracks the source of every outstanding transaction and returns in-order responses to the correct requester.

---
 rtl/riscv_memory_config_pkg.sv | 9 +
 rtl/riscv_memory_types_pkg.sv | 26 ++
 rtl/riscv_mem_src_fifo.sv | 62 ++++++
 rtl/riscv_mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_riscv_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_memory_config_pkg.sv
// Default sizing for the memory-port arbiter.
package riscv_memory_config_pkg;

    // Outstanding-transaction depth; power of two, at least 2.
    localparam int unsigned DEFAULT_MAX_OUTSTANDING = 4;
    // Consecutive data grants tolerated while fetch waits.
    localparam int unsigned DEFAULT_STARVE_LIMIT    = 4;

endpackage

// File: rtl/riscv_memory_types_pkg.sv
// Shared memory-port types: request source tag and default-width request/response bundles.
package riscv_memory_types_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 32;
    localparam int unsigned MEM_DATA_WIDTH = 32;
    localparam int unsigned MEM_STRB_WIDTH = MEM_DATA_WIDTH / 8;

    // Which requester owns an outstanding transaction.
    typedef enum logic {
        SRC_FETCH = 1'b0,
        SRC_DATA  = 1'b1
    } mem_src_e;

    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic                      we;
        logic [MEM_DATA_WIDTH-1:0] wdata;
        logic [MEM_STRB_WIDTH-1:0] wstrb;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_WIDTH-1:0] rdata;
        logic                      err;
    } mem_rsp_t;

endpackage

// File: rtl/riscv_mem_src_fifo.sv
// Synchronous FIFO of request source tags, used to route in-order responses.
module riscv_mem_src_fifo
    import riscv_memory_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  mem_src_e                   push_src_i,
    input  logic                       pop_i,
    output mem_src_e                   head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

    mem_src_e               mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_q;
    logic [PTR_WIDTH-1:0]   rd_ptr_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic                   push_en;
    logic                   pop_en;

    assign full_o  = (count_q == CNT_WIDTH'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Push on a full FIFO or pop on an empty one is ignored.
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    // Storage, pointers (wrap naturally since DEPTH is a power of two) and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= SRC_FETCH;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= push_src_i;
                wr_ptr_q        <= wr_ptr_q + PTR_WIDTH'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
            end
            unique case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CNT_WIDTH'(1);
                2'b01:   count_q <= count_q - CNT_WIDTH'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/riscv_mem_port_arbiter.sv
// Fetch/data arbiter onto one memory port: data-first priority with bounded
// fetch starvation, registered request stage, in-order response routing.
module riscv_mem_port_arbiter
    import riscv_memory_types_pkg::*;
    import riscv_memory_config_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    parameter int unsigned STARVE_LIMIT    = DEFAULT_STARVE_LIMIT
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    if_req_valid_i,
    output logic                    if_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   if_req_addr_i,
    output logic                    if_rsp_valid_o,
    input  logic                    if_rsp_ready_i,
    input  logic                    dm_req_valid_i,
    output logic                    dm_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   dm_req_addr_i,
    input  logic                    dm_req_we_i,
    input  logic [DATA_WIDTH-1:0]   dm_req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dm_req_wstrb_i,
    output logic                    dm_rsp_valid_o,
    input  logic                    dm_rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    m_req_valid_o,
    input  logic                    m_req_ready_i,
    output logic [ADDR_WIDTH-1:0]   m_req_addr_o,
    output logic                    m_req_we_o,
    output logic [DATA_WIDTH-1:0]   m_req_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_req_wstrb_o,
    input  logic                    m_rsp_valid_i,
    output logic                    m_rsp_ready_o,
    input  logic [DATA_WIDTH-1:0]   m_rsp_rdata_i,
    input  logic                    m_rsp_err_i,
    output logic                    err_unexpected_rsp_o
);

    localparam int unsigned CNT_WIDTH    = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);

    typedef enum logic {
        StIdle,
        StHold
    } state_e;

    state_e                  state_q;
    logic [STARVE_WIDTH-1:0] starve_cnt_q;
    logic                    accept_slot;
    logic                    fetch_starved;
    logic                    grant_if;
    logic                    grant_dm;
    logic                    rsp_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_WIDTH-1:0]    fifo_count;
    mem_src_e                fifo_head;

    // Winner selection; only looks at registered state so no response-to-ready path exists.
    always_comb begin
        accept_slot   = ((state_q == StIdle) || m_req_ready_i) && !fifo_full;
        fetch_starved = (starve_cnt_q == STARVE_MAX) && if_req_valid_i;
        grant_dm      = accept_slot && dm_req_valid_i && !fetch_starved;
        grant_if      = accept_slot && if_req_valid_i && !grant_dm;
    end

    assign if_req_ready_o = grant_if;
    assign dm_req_ready_o = grant_dm;

    // Request FSM with registered downstream valid and payload; payload only moves on accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            m_req_valid_o <= 1'b0;
            m_req_addr_o  <= '0;
            m_req_we_o    <= 1'b0;
            m_req_wdata_o <= '0;
            m_req_wstrb_o <= '0;
        end else if (grant_dm) begin
            state_q       <= StHold;
            m_req_valid_o <= 1'b1;
            m_req_addr_o  <= dm_req_addr_i;
            m_req_we_o    <= dm_req_we_i;
            m_req_wdata_o <= dm_req_wdata_i;
            m_req_wstrb_o <= dm_req_wstrb_i;
        end else if (grant_if) begin
            state_q       <= StHold;
            m_req_valid_o <= 1'b1;
            m_req_addr_o  <= if_req_addr_i;
            m_req_we_o    <= 1'b0;
            m_req_wdata_o <= '0;
            m_req_wstrb_o <= '0;
        end else if ((state_q == StHold) && m_req_ready_i) begin
            state_q       <= StIdle;
            m_req_valid_o <= 1'b0;
        end
    end

    // Count data grants that overtook a waiting fetch; saturates at the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else if (!if_req_valid_i || grant_if) begin
            starve_cnt_q <= '0;
        end else if (grant_dm && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_q <= starve_cnt_q + STARVE_WIDTH'(1);
        end
    end

    // Response routing by the oldest outstanding source; orphan responses are sunk.
    always_comb begin
        if_rsp_valid_o = 1'b0;
        dm_rsp_valid_o = 1'b0;
        m_rsp_ready_o  = 1'b1;
        if (!fifo_empty) begin
            if (fifo_head == SRC_FETCH) begin
                if_rsp_valid_o = m_rsp_valid_i;
                m_rsp_ready_o  = if_rsp_ready_i;
            end else begin
                dm_rsp_valid_o = m_rsp_valid_i;
                m_rsp_ready_o  = dm_rsp_ready_i;
            end
        end
    end

    assign rsp_rdata_o = m_rsp_rdata_i;
    assign rsp_err_o   = m_rsp_err_i;
    assign rsp_pop     = m_rsp_valid_i && m_rsp_ready_o && !fifo_empty;

    // Sticky flag for a response with nothing outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_unexpected_rsp_o <= 1'b0;
        end else if (m_rsp_valid_i && (fifo_count == '0)) begin
            err_unexpected_rsp_o <= 1'b1;
        end
    end

    riscv_mem_src_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_src_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (grant_if || grant_dm),
        .push_src_i (grant_dm ? SRC_DATA : SRC_FETCH),
        .pop_i      (rsp_pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

endmodule

// File: tb/tb_riscv_mem_port_arbiter.sv
// Directed and randomized checks of the memory-port arbiter against a
// transaction-level model (queue of outstanding sources, starvation counter).
module tb_riscv_mem_port_arbiter;
    import riscv_memory_types_pkg::*;

    localparam int STARVE = 4;
    localparam int MAXO   = 4;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        if_req_valid_i, if_req_ready_o, if_rsp_valid_o, if_rsp_ready_i;
    logic [31:0] if_req_addr_i;
    logic        dm_req_valid_i, dm_req_ready_o, dm_req_we_i, dm_rsp_valid_o, dm_rsp_ready_i;
    logic [31:0] dm_req_addr_i, dm_req_wdata_i;
    logic [3:0]  dm_req_wstrb_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        m_req_valid_o, m_req_ready_i, m_req_we_o;
    logic [31:0] m_req_addr_o, m_req_wdata_o;
    logic [3:0]  m_req_wstrb_o;
    logic        m_rsp_valid_i, m_rsp_ready_o, m_rsp_err_i;
    logic [31:0] m_rsp_rdata_i;
    logic        err_unexpected_rsp_o;

    riscv_mem_port_arbiter dut (
        .clk_i                (clk),
        .rst_ni               (rst_ni),
        .if_req_valid_i       (if_req_valid_i),
        .if_req_ready_o       (if_req_ready_o),
        .if_req_addr_i        (if_req_addr_i),
        .if_rsp_valid_o       (if_rsp_valid_o),
        .if_rsp_ready_i       (if_rsp_ready_i),
        .dm_req_valid_i       (dm_req_valid_i),
        .dm_req_ready_o       (dm_req_ready_o),
        .dm_req_addr_i        (dm_req_addr_i),
        .dm_req_we_i          (dm_req_we_i),
        .dm_req_wdata_i       (dm_req_wdata_i),
        .dm_req_wstrb_i       (dm_req_wstrb_i),
        .dm_rsp_valid_o       (dm_rsp_valid_o),
        .dm_rsp_ready_i       (dm_rsp_ready_i),
        .rsp_rdata_o          (rsp_rdata_o),
        .rsp_err_o            (rsp_err_o),
        .m_req_valid_o        (m_req_valid_o),
        .m_req_ready_i        (m_req_ready_i),
        .m_req_addr_o         (m_req_addr_o),
        .m_req_we_o           (m_req_we_o),
        .m_req_wdata_o        (m_req_wdata_o),
        .m_req_wstrb_o        (m_req_wstrb_o),
        .m_rsp_valid_i        (m_rsp_valid_i),
        .m_rsp_ready_o        (m_rsp_ready_o),
        .m_rsp_rdata_i        (m_rsp_rdata_i),
        .m_rsp_err_i          (m_rsp_err_i),
        .err_unexpected_rsp_o (err_unexpected_rsp_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_hold;
    int          starve;
    mem_src_e    src_q[$];
    bit          sticky;
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [3:0]  e_wstrb;
    string       dut_grants;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string obs, input string exp);
        n_checks++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed '%s' expected '%s'", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hold = 0;
        starve = 0;
        src_q.delete();
        sticky = 0;
        e_addr = '0; e_wdata = '0; e_we = 1'b0; e_wstrb = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_m_req_valid"}, m_req_valid_o, 0);
        chk({tag, "_m_req_addr"}, m_req_addr_o, 0);
        chk({tag, "_m_req_we"}, m_req_we_o, 0);
        chk({tag, "_m_req_wdata"}, m_req_wdata_o, 0);
        chk({tag, "_m_req_wstrb"}, m_req_wstrb_o, 0);
        chk({tag, "_if_req_ready"}, if_req_ready_o, 0);
        chk({tag, "_dm_req_ready"}, dm_req_ready_o, 0);
        chk({tag, "_if_rsp_valid"}, if_rsp_valid_o, 0);
        chk({tag, "_dm_rsp_valid"}, dm_rsp_valid_o, 0);
        chk({tag, "_err_unexpected"}, err_unexpected_rsp_o, 0);
    endtask

    // One clock: called at a negedge with inputs already driven; checks, then advances the model.
    task automatic step();
        bit slot, gi, gd, empty, head_f, exp_mready;
        #1;
        slot  = (!m_hold || m_req_ready_i) && (src_q.size() < MAXO);
        gd    = slot && dm_req_valid_i && !(starve == STARVE && if_req_valid_i);
        gi    = slot && if_req_valid_i && !gd;
        empty = (src_q.size() == 0);
        head_f = !empty && (src_q[0] == SRC_FETCH);
        exp_mready = empty ? 1'b1 : (head_f ? if_rsp_ready_i : dm_rsp_ready_i);
        chk("if_req_ready", if_req_ready_o, gi);
        chk("dm_req_ready", dm_req_ready_o, gd);
        chk("m_req_valid", m_req_valid_o, m_hold);
        if (m_hold) begin
            chk("m_req_addr", m_req_addr_o, e_addr);
            chk("m_req_we", m_req_we_o, e_we);
            chk("m_req_wdata", m_req_wdata_o, e_wdata);
            chk("m_req_wstrb", m_req_wstrb_o, e_wstrb);
        end
        chk("if_rsp_valid", if_rsp_valid_o, m_rsp_valid_i && head_f);
        chk("dm_rsp_valid", dm_rsp_valid_o, m_rsp_valid_i && !empty && !head_f);
        chk("m_rsp_ready", m_rsp_ready_o, exp_mready);
        chk("rsp_rdata", rsp_rdata_o, m_rsp_rdata_i);
        chk("rsp_err", rsp_err_o, m_rsp_err_i);
        chk("err_unexpected", err_unexpected_rsp_o, sticky);
        if (if_req_valid_i && if_req_ready_o) dut_grants = {dut_grants, "F"};
        if (dm_req_valid_i && dm_req_ready_o) dut_grants = {dut_grants, "D"};
        @(posedge clk);
        if (m_rsp_valid_i && empty) sticky = 1;
        if (m_rsp_valid_i && exp_mready && !empty) void'(src_q.pop_front());
        if (gd) begin
            src_q.push_back(SRC_DATA);
            e_addr = dm_req_addr_i; e_we = dm_req_we_i;
            e_wdata = dm_req_wdata_i; e_wstrb = dm_req_wstrb_i;
        end else if (gi) begin
            src_q.push_back(SRC_FETCH);
            e_addr = if_req_addr_i; e_we = 1'b0; e_wdata = '0; e_wstrb = '0;
        end
        if (gi || gd) m_hold = 1;
        else if (m_req_ready_i) m_hold = 0;
        if (!if_req_valid_i || gi) starve = 0;
        else if (gd && starve < STARVE) starve++;
        @(negedge clk);
    endtask

    // Return every outstanding response and let the request stage empty.
    task automatic drain();
        if_req_valid_i = 0; dm_req_valid_i = 0; m_req_ready_i = 1;
        if_rsp_ready_i = 1; dm_rsp_ready_i = 1;
        for (int i = 0; i < 8; i++) begin
            m_rsp_valid_i = (src_q.size() > 0);
            m_rsp_rdata_i = $urandom;
            step();
        end
        m_rsp_valid_i = 0;
    endtask

    initial begin
        rst_ni = 0;
        if_req_valid_i = 0; if_req_addr_i = '0; if_rsp_ready_i = 0;
        dm_req_valid_i = 0; dm_req_addr_i = '0; dm_req_we_i = 0;
        dm_req_wdata_i = '0; dm_req_wstrb_i = '0; dm_rsp_ready_i = 0;
        m_req_ready_i = 0; m_rsp_valid_i = 0; m_rsp_rdata_i = '0; m_rsp_err_i = 0;
        model_reset();
        @(negedge clk); #1;
        check_reset("por");
        @(negedge clk);
        rst_ni = 1;

        // Both requesters saturating: fetch wins every fifth grant.
        dut_grants = "";
        if_req_valid_i = 1; dm_req_valid_i = 1; m_req_ready_i = 1;
        if_rsp_ready_i = 1; dm_rsp_ready_i = 1;
        for (int i = 0; i < 15; i++) begin
            if_req_addr_i = $urandom; dm_req_addr_i = $urandom;
            dm_req_we_i = 1'($urandom_range(0, 1));
            dm_req_wdata_i = $urandom; dm_req_wstrb_i = 4'($urandom_range(0, 15));
            m_rsp_valid_i = (src_q.size() >= 2);
            m_rsp_rdata_i = $urandom;
            step();
        end
        chk_str("starve_order", dut_grants, "DDDDFDDDDFDDDDF");
        drain();

        // Data write held off downstream for three cycles.
        dm_req_valid_i = 1; dm_req_addr_i = 32'h100; dm_req_we_i = 1;
        dm_req_wdata_i = 32'hDEADBEEF; dm_req_wstrb_i = 4'hF; m_req_ready_i = 0;
        step();
        dm_req_valid_i = 0; dm_req_addr_i = '0; dm_req_we_i = 0;
        dm_req_wdata_i = '0; dm_req_wstrb_i = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wr_hold_addr", m_req_addr_o, 32'h100);
            chk("wr_hold_wdata", m_req_wdata_o, 32'hDEADBEEF);
            chk("wr_hold_valid", m_req_valid_o, 1);
        end
        m_req_ready_i = 1;
        step();
        chk("wr_fifo_count", dut.fifo_count, 1);
        chk("wr_released", m_req_valid_o, 0);
        drain();

        // Fill the source FIFO with fetches; a pop in the same cycle must not admit a new one.
        dut_grants = "";
        if_req_valid_i = 1; m_req_ready_i = 1;
        for (int i = 0; i < 6; i++) begin
            if_req_addr_i = $urandom;
            step();
        end
        chk_str("full_four_grants", dut_grants, "FFFF");
        chk("full_count", dut.fifo_count, 4);
        m_rsp_valid_i = 1; if_rsp_ready_i = 1; m_rsp_rdata_i = $urandom;
        step();
        chk_str("full_blocked_on_pop", dut_grants, "FFFF");
        m_rsp_valid_i = 0;
        step();
        chk_str("full_accept_after_pop", dut_grants, "FFFFF");
        drain();

        // Interleaved F,D,F with data-side response backpressure.
        m_req_ready_i = 1;
        if_req_valid_i = 1; if_req_addr_i = 32'h10; step();
        if_req_valid_i = 0; dm_req_valid_i = 1; dm_req_addr_i = 32'h20; step();
        dm_req_valid_i = 0; if_req_valid_i = 1; if_req_addr_i = 32'h30; step();
        if_req_valid_i = 0; step();
        m_rsp_valid_i = 1; m_rsp_rdata_i = 32'h1; if_rsp_ready_i = 1; dm_rsp_ready_i = 0;
        #1;
        chk("ilv_rsp1_if_valid", if_rsp_valid_o, 1);
        chk("ilv_rsp1_dm_valid", dm_rsp_valid_o, 0);
        chk("ilv_rsp1_rdata", rsp_rdata_o, 32'h1);
        step();
        m_rsp_rdata_i = 32'h2;
        #1;
        chk("ilv_rsp2_dm_valid", dm_rsp_valid_o, 1);
        chk("ilv_rsp2_if_valid", if_rsp_valid_o, 0);
        chk("ilv_rsp2_backpressure", m_rsp_ready_o, 0);
        step();
        dm_rsp_ready_i = 1;
        #1;
        chk("ilv_rsp2_ready", m_rsp_ready_o, 1);
        step();
        m_rsp_rdata_i = 32'h3;
        #1;
        chk("ilv_rsp3_if_valid", if_rsp_valid_o, 1);
        chk("ilv_rsp3_rdata", rsp_rdata_o, 32'h3);
        step();
        m_rsp_valid_i = 0;
        step();

        // Orphan response: sunk and flagged, flag holds.
        m_rsp_valid_i = 1; m_rsp_rdata_i = 32'hBAD;
        #1;
        chk("unexp_ready", m_rsp_ready_o, 1);
        chk("unexp_if_valid", if_rsp_valid_o, 0);
        chk("unexp_dm_valid", dm_rsp_valid_o, 0);
        step();
        m_rsp_valid_i = 0;
        chk("unexp_set", err_unexpected_rsp_o, 1);
        step();
        step();
        chk("unexp_sticky", err_unexpected_rsp_o, 1);

        // Reset while holding a request with two outstanding.
        m_req_ready_i = 0; if_req_valid_i = 1; if_req_addr_i = 32'h40; step();
        if_req_valid_i = 0; dm_req_valid_i = 1; dm_req_addr_i = 32'h50; m_req_ready_i = 1; step();
        chk("mid_pre_count", dut.fifo_count, 2);
        dm_req_valid_i = 0; m_req_ready_i = 0;
        rst_ni = 0;
        model_reset();
        #1;
        check_reset("mid_rst");
        chk("mid_rst_count", dut.fifo_count, 0);
        @(negedge clk);
        rst_ni = 1;
        m_rsp_valid_i = 1; m_rsp_rdata_i = $urandom;
        step();
        m_rsp_valid_i = 0;
        chk("stale_flagged", err_unexpected_rsp_o, 1);
        if_req_valid_i = 1; if_req_addr_i = 32'h200; m_req_ready_i = 1;
        step();
        chk("post_rst_valid", m_req_valid_o, 1);
        chk("post_rst_addr", m_req_addr_o, 32'h200);
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if_req_valid_i = 1'($urandom_range(0, 1));
            dm_req_valid_i = 1'($urandom_range(0, 1));
            if_req_addr_i = $urandom; dm_req_addr_i = $urandom;
            dm_req_we_i = 1'($urandom_range(0, 1));
            dm_req_wdata_i = $urandom; dm_req_wstrb_i = 4'($urandom_range(0, 15));
            m_req_ready_i = ($urandom_range(0, 3) != 0);
            if_rsp_ready_i = ($urandom_range(0, 3) != 0);
            dm_rsp_ready_i = ($urandom_range(0, 3) != 0);
            m_rsp_valid_i = (src_q.size() > 0) ? 1'($urandom_range(0, 1))
                                                : ($urandom_range(0, 19) == 0);
            m_rsp_rdata_i = $urandom;
            m_rsp_err_i = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
